// File: rtl/fetch_window_pkg.sv
// fetch_window_pkg
//   Shared constants and types for the instruction prefetch window.
//   WINDOW_BYTES  : bytes presented to the decoder each cycle
//   MAX_INSTR_LEN : longest instruction the decoder may consume at once
//   byte_t        : one byte lane of the prefetch buffer
package fetch_window_pkg;

    localparam int WINDOW_BYTES  = 12;
    localparam int MAX_INSTR_LEN = 12;
    localparam int WORD_BYTES    = 4;

    typedef logic [7:0] byte_t;

    // A decoder-reported length is usable only if it is 1..MAX_INSTR_LEN.
    function automatic logic len_legal(input logic [3:0] len);
        return (len != 4'd0) && (len <= 4'(MAX_INSTR_LEN));
    endfunction

endpackage

// File: rtl/fetch_window_shift.sv
// fetch_window_shift
//   Combinational next-state datapath for the prefetch buffer: drops the
//   consumed bytes off the bottom and appends an optional fetch word right
//   after the last byte that survives the consume.
//   buf_i     : current buffer, byte 0 oldest
//   fill_i    : number of valid bytes in buf_i
//   shamt_i   : bytes consumed this cycle (0 when nothing is consumed)
//   wr_en_i   : append wr_data_i this cycle
//   wr_data_i : fetch word, byte 0 in [7:0]
//   buf_o     : next buffer; every byte at or above the new fill is 0
module fetch_window_shift
    import fetch_window_pkg::*;
#(
    parameter int BUF_BYTES = 16,
    parameter int CNT_W     = 5
) (
    input  byte_t [BUF_BYTES-1:0] buf_i,
    input  logic  [CNT_W-1:0]     fill_i,
    input  logic  [3:0]           shamt_i,
    input  logic                  wr_en_i,
    input  logic  [31:0]          wr_data_i,
    output byte_t [BUF_BYTES-1:0] buf_o
);

    localparam int IDX_W = $clog2(BUF_BYTES);

    always_comb begin
        int               fill;
        int               base;
        int               src;
        int               off;
        logic [IDX_W-1:0] idx;
        logic [1:0]       lane;

        fill  = int'(fill_i);
        base  = fill - int'(shamt_i);
        src   = 0;
        off   = 0;
        idx   = '0;
        lane  = '0;
        buf_o = '0;

        for (int i = 0; i < BUF_BYTES; i++) begin
            // Surviving bytes slide down; anything past the old fill stays 0
            // so stale data never reappears on the decode window.
            src = i + int'(shamt_i);
            idx = IDX_W'(src);
            if (src < fill) begin
                buf_o[i] = buf_i[idx];
            end

            // The write lands on the four slots starting at the post-consume
            // fill. The caller guarantees those slots are inside the buffer.
            off  = i - base;
            lane = 2'(off);
            if (wr_en_i && (off >= 0) && (off < WORD_BYTES)) begin
                buf_o[i] = wr_data_i[{lane, 3'b000} +: 8];
            end
        end
    end

endmodule

// File: rtl/fetch_window.sv
// fetch_window
//   Byte-granular instruction prefetch buffer. Fetch words enter at the top,
//   the decoder sees the oldest WINDOW_BYTES bytes and retires a variable
//   number of them per cycle. A redirect flushes everything and restarts at
//   a new address.
//   clk, rst_n            : clock, asynchronous active-low reset
//   redirect/redirect_eip : flush and restart address (highest priority)
//   fetch_data/valid      : incoming code word; fetch_ready is the accept
//   raw_instr/instr_valid : decode window and its full-window qualifier
//   instr_eip             : address of raw_instr byte 0
//   instr_len/accept      : decoder consume request
//   len_error             : sticky flag for an accept with an illegal length
//   fill_level            : valid byte count
module fetch_window
    import fetch_window_pkg::*;
#(
    parameter int BUF_BYTES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect,
    input  logic [31:0] redirect_eip,
    input  logic [31:0] fetch_data,
    input  logic        fetch_valid,
    output logic        fetch_ready,
    output logic [95:0] raw_instr,
    output logic        instr_valid,
    output logic [31:0] instr_eip,
    input  logic [3:0]  instr_len,
    input  logic        instr_accept,
    output logic        len_error,
    output logic [4:0]  fill_level
);

    localparam int CNT_W = $clog2(BUF_BYTES + 1);

    byte_t [BUF_BYTES-1:0] buf_q, buf_d, buf_shift;
    logic  [CNT_W-1:0]     fill_q, fill_d;
    logic  [31:0]          eip_q, eip_d;
    logic                  len_err_q, len_err_d;

    logic                  consume;
    logic                  len_bad;
    logic                  wr_en;
    logic  [3:0]           shamt;

    // Handshake/qualifiers come from registered fill only, so no input can
    // reach fetch_ready or instr_valid combinationally.
    assign fetch_ready = (fill_q <= CNT_W'(BUF_BYTES - WORD_BYTES));
    assign instr_valid = (fill_q >= CNT_W'(WINDOW_BYTES));
    assign raw_instr   = buf_q[WINDOW_BYTES-1:0];
    assign instr_eip   = eip_q;
    assign len_error   = len_err_q;
    assign fill_level  = 5'(fill_q);

    always_comb begin
        consume = instr_accept && instr_valid && !redirect && len_legal(instr_len);
        // Accepts against a partial window are silently dropped, not errors.
        len_bad = instr_accept && instr_valid && !len_legal(instr_len);
        // fetch_ready already leaves room for a full word even with no consume,
        // so a write can never push fill past BUF_BYTES.
        wr_en   = fetch_valid && fetch_ready && !redirect;
        shamt   = consume ? instr_len : 4'd0;
    end

    fetch_window_shift #(
        .BUF_BYTES (BUF_BYTES),
        .CNT_W     (CNT_W)
    ) u_shift (
        .buf_i     (buf_q),
        .fill_i    (fill_q),
        .shamt_i   (shamt),
        .wr_en_i   (wr_en),
        .wr_data_i (fetch_data),
        .buf_o     (buf_shift)
    );

    always_comb begin
        buf_d     = buf_shift;
        fill_d    = fill_q - CNT_W'(shamt) + (wr_en ? CNT_W'(WORD_BYTES) : '0);
        eip_d     = eip_q + {28'd0, shamt};
        len_err_d = len_err_q | len_bad;

        // Redirect overrides any same-cycle write, consume or length error.
        if (redirect) begin
            buf_d     = '0;
            fill_d    = '0;
            eip_d     = redirect_eip;
            len_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q     <= '0;
            fill_q    <= '0;
            eip_q     <= '0;
            len_err_q <= 1'b0;
        end else begin
            buf_q     <= buf_d;
            fill_q    <= fill_d;
            eip_q     <= eip_d;
            len_err_q <= len_err_d;
        end
    end

endmodule

// File: tb/tb_fetch_window.sv
// tb_fetch_window
//   Directed scenarios for fetch_window with hand-computed expectations.
module tb_fetch_window;

    logic        clk;
    logic        rst_n;
    logic        redirect;
    logic [31:0] redirect_eip;
    logic [31:0] fetch_data;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [95:0] raw_instr;
    logic        instr_valid;
    logic [31:0] instr_eip;
    logic [3:0]  instr_len;
    logic        instr_accept;
    logic        len_error;
    logic [4:0]  fill_level;

    int checks = 0;
    int errors = 0;

    fetch_window #(.BUF_BYTES(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .redirect     (redirect),
        .redirect_eip (redirect_eip),
        .fetch_data   (fetch_data),
        .fetch_valid  (fetch_valid),
        .fetch_ready  (fetch_ready),
        .raw_instr    (raw_instr),
        .instr_valid  (instr_valid),
        .instr_eip    (instr_eip),
        .instr_len    (instr_len),
        .instr_accept (instr_accept),
        .len_error    (len_error),
        .fill_level   (fill_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs change and outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        redirect     = 1'b0;
        fetch_valid  = 1'b0;
        instr_accept = 1'b0;
        instr_len    = 4'd0;
    endtask

    task automatic write_word(input logic [31:0] w);
        fetch_data  = w;
        fetch_valid = 1'b1;
        tick();
        fetch_valid = 1'b0;
    endtask

    task automatic do_redirect(input logic [31:0] eip);
        redirect     = 1'b1;
        redirect_eip = eip;
        tick();
        redirect     = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        fetch_data   = 32'hA5A5A5A5;
        redirect_eip = 32'h0;
        tick();
        tick();
        checks++; if (fill_level !== 5'd0) begin errors++; $display("FAIL reset_fill got %0d exp 0", fill_level); end
        checks++; if (instr_eip !== 32'h0) begin errors++; $display("FAIL reset_eip got %h exp 0", instr_eip); end
        checks++; if (len_error !== 1'b0) begin errors++; $display("FAIL reset_len_error got %b exp 0", len_error); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", instr_valid); end
        checks++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", fetch_ready); end
        checks++; if (raw_instr !== 96'h0) begin errors++; $display("FAIL reset_raw got %h exp 0", raw_instr); end
        #3 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fill();
        write_word(32'h03020100);
        // Next-cycle visibility of a freshly written word.
        checks++; if (raw_instr !== 96'h000000000000000003020100) begin errors++; $display("FAIL fill_latency got %h exp %h", raw_instr, 96'h3020100); end
        checks++; if (fill_level !== 5'd4) begin errors++; $display("FAIL fill_first got %0d exp 4", fill_level); end
        write_word(32'h07060504);
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL fill_valid8 got %b exp 0", instr_valid); end
        write_word(32'h0B0A0908);
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL fill_valid got %b exp 1", instr_valid); end
        checks++; if (raw_instr !== 96'h0B0A09080706050403020100) begin errors++; $display("FAIL fill_raw got %h exp %h", raw_instr, 96'h0B0A09080706050403020100); end
        checks++; if (fill_level !== 5'd12) begin errors++; $display("FAIL fill_level got %0d exp 12", fill_level); end
        // 12 <= BUF_BYTES-4, so there is still room for one word.
        checks++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL fill_ready12 got %b exp 1", fetch_ready); end
    endtask

    task automatic test_consume_write();
        write_word(32'h0F0E0D0C);
        checks++; if (fill_level !== 5'd16) begin errors++; $display("FAIL cw_full got %0d exp 16", fill_level); end
        checks++; if (fetch_ready !== 1'b0) begin errors++; $display("FAIL cw_ready_full got %b exp 0", fetch_ready); end
        // Full buffer: the offered word must be refused while the consume goes through.
        instr_len    = 4'd3;
        instr_accept = 1'b1;
        fetch_data   = 32'h13121110;
        fetch_valid  = 1'b1;
        tick();
        idle();
        checks++; if (fill_level !== 5'd13) begin errors++; $display("FAIL cw_fill got %0d exp 13", fill_level); end
        checks++; if (raw_instr[7:0] !== 8'h03) begin errors++; $display("FAIL cw_byte0 got %h exp 03", raw_instr[7:0]); end
        checks++; if (raw_instr !== 96'h0E0D0C0B0A09080706050403) begin errors++; $display("FAIL cw_raw got %h exp %h", raw_instr, 96'h0E0D0C0B0A09080706050403); end
        checks++; if (instr_eip !== 32'd3) begin errors++; $display("FAIL cw_eip got %h exp 3", instr_eip); end
        checks++; if (fetch_ready !== 1'b0) begin errors++; $display("FAIL cw_ready13 got %b exp 0", fetch_ready); end
    endtask

    task automatic test_redirect();
        instr_len    = 4'd2;
        instr_accept = 1'b1;
        fetch_data   = 32'h99999999;
        fetch_valid  = 1'b1;
        redirect     = 1'b1;
        redirect_eip = 32'h00401000;
        tick();
        idle();
        checks++; if (fill_level !== 5'd0) begin errors++; $display("FAIL redir_fill got %0d exp 0", fill_level); end
        checks++; if (instr_eip !== 32'h00401000) begin errors++; $display("FAIL redir_eip got %h exp 00401000", instr_eip); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_valid got %b exp 0", instr_valid); end
        checks++; if (raw_instr !== 96'h0) begin errors++; $display("FAIL redir_raw got %h exp 0", raw_instr); end
        write_word(32'hDDCCBBAA);
        checks++; if (raw_instr !== 96'h0000000000000000DDCCBBAA) begin errors++; $display("FAIL redir_first_word got %h exp DDCCBBAA", raw_instr); end
    endtask

    task automatic test_len_error();
        write_word(32'h44332211);
        write_word(32'h88776655);
        checks++; if (raw_instr !== 96'h8877665544332211DDCCBBAA) begin errors++; $display("FAIL le_raw got %h exp %h", raw_instr, 96'h8877665544332211DDCCBBAA); end
        instr_len    = 4'd0;
        instr_accept = 1'b1;
        tick();
        idle();
        checks++; if (len_error !== 1'b1) begin errors++; $display("FAIL le_len0 got %b exp 1", len_error); end
        checks++; if (fill_level !== 5'd12) begin errors++; $display("FAIL le_fill0 got %0d exp 12", fill_level); end
        checks++; if (instr_eip !== 32'h00401000) begin errors++; $display("FAIL le_eip0 got %h exp 00401000", instr_eip); end
        instr_len    = 4'd13;
        instr_accept = 1'b1;
        tick();
        idle();
        checks++; if (len_error !== 1'b1) begin errors++; $display("FAIL le_len13 got %b exp 1", len_error); end
        checks++; if (fill_level !== 5'd12) begin errors++; $display("FAIL le_fill13 got %0d exp 12", fill_level); end
        checks++; if (raw_instr !== 96'h8877665544332211DDCCBBAA) begin errors++; $display("FAIL le_raw13 got %h exp %h", raw_instr, 96'h8877665544332211DDCCBBAA); end
        tick();
        checks++; if (len_error !== 1'b1) begin errors++; $display("FAIL le_sticky got %b exp 1", len_error); end
        do_redirect(32'h00001000);
        checks++; if (len_error !== 1'b0) begin errors++; $display("FAIL le_clear got %b exp 0", len_error); end
        checks++; if (instr_eip !== 32'h00001000) begin errors++; $display("FAIL le_redir_eip got %h exp 00001000", instr_eip); end
    endtask

    task automatic test_back_to_back();
        do_redirect(32'h0);
        write_word(32'h03020100);
        write_word(32'h07060504);
        write_word(32'h0B0A0908);
        // Consume and write together at fill 12: 12 - 5 + 4 = 11.
        instr_len    = 4'd5;
        instr_accept = 1'b1;
        fetch_data   = 32'h0F0E0D0C;
        fetch_valid  = 1'b1;
        tick();
        idle();
        checks++; if (fill_level !== 5'd11) begin errors++; $display("FAIL b2b_fill got %0d exp 11", fill_level); end
        checks++; if (raw_instr !== 96'h000F0E0D0C0B0A0908070605) begin errors++; $display("FAIL b2b_raw got %h exp %h", raw_instr, 96'h000F0E0D0C0B0A0908070605); end
        checks++; if (instr_eip !== 32'd5) begin errors++; $display("FAIL b2b_eip got %h exp 5", instr_eip); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid got %b exp 0", instr_valid); end
        // Accept against a partial window: ignored and no length error.
        instr_len    = 4'd0;
        instr_accept = 1'b1;
        tick();
        instr_len    = 4'd4;
        tick();
        idle();
        checks++; if (len_error !== 1'b0) begin errors++; $display("FAIL b2b_inv_err got %b exp 0", len_error); end
        checks++; if (fill_level !== 5'd11) begin errors++; $display("FAIL b2b_inv_fill got %0d exp 11", fill_level); end
        checks++; if (instr_eip !== 32'd5) begin errors++; $display("FAIL b2b_inv_eip got %h exp 5", instr_eip); end
        write_word(32'h13121110);
        checks++; if (fill_level !== 5'd15) begin errors++; $display("FAIL b2b_fill15 got %0d exp 15", fill_level); end
        // Maximum length consume leaves bytes 0x11..0x13.
        instr_len    = 4'd12;
        instr_accept = 1'b1;
        tick();
        idle();
        checks++; if (fill_level !== 5'd3) begin errors++; $display("FAIL b2b_len12_fill got %0d exp 3", fill_level); end
        checks++; if (raw_instr !== 96'h000000000000000000131211) begin errors++; $display("FAIL b2b_len12_raw got %h exp 131211", raw_instr); end
        checks++; if (instr_eip !== 32'd17) begin errors++; $display("FAIL b2b_len12_eip got %h exp 11", instr_eip); end
    endtask

    task automatic test_wrap_reset();
        do_redirect(32'hFFFFFFFE);
        write_word(32'h03020100);
        write_word(32'h07060504);
        write_word(32'h0B0A0908);
        instr_len    = 4'd0;
        instr_accept = 1'b1;
        tick();
        instr_len    = 4'd4;
        tick();
        idle();
        checks++; if (instr_eip !== 32'h00000002) begin errors++; $display("FAIL wrap_eip got %h exp 00000002", instr_eip); end
        checks++; if (fill_level !== 5'd8) begin errors++; $display("FAIL wrap_fill got %0d exp 8", fill_level); end
        checks++; if (raw_instr !== 96'h000000000B0A090807060504) begin errors++; $display("FAIL wrap_raw got %h exp %h", raw_instr, 96'h0B0A090807060504); end
        checks++; if (len_error !== 1'b1) begin errors++; $display("FAIL wrap_err got %b exp 1", len_error); end
        // Reset asserted between edges while a write is being offered.
        fetch_data  = 32'h77777777;
        fetch_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (fill_level !== 5'd0) begin errors++; $display("FAIL arst_fill got %0d exp 0", fill_level); end
        checks++; if (instr_eip !== 32'h0) begin errors++; $display("FAIL arst_eip got %h exp 0", instr_eip); end
        checks++; if (len_error !== 1'b0) begin errors++; $display("FAIL arst_err got %b exp 0", len_error); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got %b exp 0", instr_valid); end
        checks++; if (fetch_ready !== 1'b1) begin errors++; $display("FAIL arst_ready got %b exp 1", fetch_ready); end
        checks++; if (raw_instr !== 96'h0) begin errors++; $display("FAIL arst_raw got %h exp 0", raw_instr); end
        tick();
        fetch_valid = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        write_word(32'hCAFEF00D);
        checks++; if (raw_instr !== 96'h0000000000000000CAFEF00D) begin errors++; $display("FAIL post_rst_raw got %h exp CAFEF00D", raw_instr); end
        checks++; if (fill_level !== 5'd4) begin errors++; $display("FAIL post_rst_fill got %0d exp 4", fill_level); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_consume_write();
        test_redirect();
        test_len_error();
        test_back_to_back();
        test_wrap_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
